// File: rtl/midi_framer_pkg.sv
// ============================================================================
// midi_framer_pkg : shared MIDI constants, event record and data-length helper
// Rev 1.0
// ============================================================================
`default_nettype none

package midi_framer_pkg;

   localparam logic [3:0] NOTE_OFF   = 4'h8;
   localparam logic [3:0] NOTE_ON    = 4'h9;
   localparam logic [3:0] POLY_AT    = 4'hA;
   localparam logic [3:0] CC         = 4'hB;
   localparam logic [3:0] PROG       = 4'hC;
   localparam logic [3:0] CHAN_AT    = 4'hD;
   localparam logic [3:0] PITCH_BEND = 4'hE;

   localparam logic [7:0] SYSEX_START  = 8'hF0;
   localparam logic [7:0] SYSEX_END    = 8'hF7;
   localparam logic [7:0] REALTIME_MIN = 8'hF8;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT_P1 = 2'd1;
   localparam logic [1:0] ST_WAIT_P2 = 2'd2;
   localparam logic [1:0] ST_SKIP    = 2'd3;

   typedef struct packed {
      logic [7:0] command;
      logic [6:0] p1;
      logic [6:0] p2;
   } midi_event_t;

   // Number of data bytes that follow a status byte (0 for SysEx/undefined/F6/F7).
   function automatic logic [1:0] data_length(input logic [7:0] status);
      logic [1:0] len;
      len = 2'd0;
      if (status[7:4] == PROG || status[7:4] == CHAN_AT)
         len = 2'd1;
      else if (status[7:4] == NOTE_OFF || status[7:4] == NOTE_ON || status[7:4] == POLY_AT ||
               status[7:4] == CC || status[7:4] == PITCH_BEND)
         len = 2'd2;
      else if (status == 8'hF1 || status == 8'hF3)
         len = 2'd1;
      else if (status == 8'hF2)
         len = 2'd2;
      return len;
   endfunction

endpackage

`default_nettype wire

// File: rtl/midi_event_fifo.sv
// ============================================================================
// midi_event_fifo : show-ahead event FIFO with level count and sticky overflow
// Rev 1.0
// ============================================================================
`default_nettype none

module midi_event_fifo
   import midi_framer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH),
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          push,
   input  midi_event_t   push_event,
   input  logic          pop,
   output midi_event_t   head,
   output logic          valid,
   output logic [LW-1:0] level,
   output logic          overflow
);

   midi_event_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_pop;
   logic          do_push;

   assign valid   = (level != '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop && valid;
   // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_event;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            level <= level + LW'(1);
         else if (do_pop && !do_push)
            level <= level - LW'(1);
         if (push && !do_push)
            overflow <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/midi_framer.sv
// ============================================================================
// midi_framer : MIDI byte stream parser producing buffered channel-voice events
// Rev 1.0
// ============================================================================
`default_nettype none

module midi_framer
   import midi_framer_pkg::*;
#(
   parameter int FIFO_DEPTH      = 4,
   parameter bit VEL0_TO_NOTEOFF = 1'b1
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        byte_valid,
   input  logic [7:0]                  byte_data,
   output logic                        midi_event_valid,
   output logic [7:0]                  midi_command,
   output logic [6:0]                  midi_parameter_1,
   output logic [6:0]                  midi_parameter_2,
   input  logic                        midi_event_ack,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   logic [1:0]  state, state_next;
   logic [7:0]  run_status, run_status_next;
   logic [6:0]  p1_q, p1_next;
   logic [1:0]  skip_cnt, skip_cnt_next;
   logic        skip_forever, skip_forever_next;
   logic        is_data, is_chan_status, is_sys_status;
   logic        emit;
   midi_event_t emit_event;
   midi_event_t head;

   assign is_data        = !byte_data[7];
   assign is_chan_status = byte_data[7] && (byte_data[7:4] != 4'hF);
   assign is_sys_status  = (byte_data[7:4] == 4'hF) && (byte_data < REALTIME_MIN);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         run_status   <= '0;
         p1_q         <= '0;
         skip_cnt     <= '0;
         skip_forever <= 1'b0;
      end else begin
         state        <= state_next;
         run_status   <= run_status_next;
         p1_q         <= p1_next;
         skip_cnt     <= skip_cnt_next;
         skip_forever <= skip_forever_next;
      end
   end

   // Real-time bytes fall through every branch below and so disturb nothing.
   always_comb begin
      state_next        = state;
      run_status_next   = run_status;
      p1_next           = p1_q;
      skip_cnt_next     = skip_cnt;
      skip_forever_next = skip_forever;
      if (byte_valid) begin
         if (is_chan_status) begin
            run_status_next = byte_data;
            state_next      = ST_WAIT_P1;
         end else if (is_sys_status) begin
            run_status_next   = '0;
            skip_forever_next = (byte_data == SYSEX_START);
            skip_cnt_next     = data_length(byte_data);
            if (byte_data == SYSEX_START)
               state_next = ST_SKIP;
            else if (byte_data == SYSEX_END || data_length(byte_data) == 2'd0)
               state_next = ST_IDLE;
            else
               state_next = ST_SKIP;
         end else if (is_data) begin
            case (state)
               ST_WAIT_P1: begin
                  p1_next = byte_data[6:0];
                  if (data_length(run_status) == 2'd2)
                     state_next = ST_WAIT_P2;
               end
               ST_WAIT_P2: state_next = ST_WAIT_P1;
               ST_SKIP: begin
                  if (!skip_forever) begin
                     skip_cnt_next = skip_cnt - 2'd1;
                     if (skip_cnt == 2'd1)
                        state_next = ST_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      emit       = 1'b0;
      emit_event = '0;
      if (byte_valid && is_data) begin
         if (state == ST_WAIT_P1 && data_length(run_status) == 2'd1) begin
            emit               = 1'b1;
            emit_event.command = run_status;
            emit_event.p1      = byte_data[6:0];
            emit_event.p2      = 7'd0;
         end else if (state == ST_WAIT_P2) begin
            emit               = 1'b1;
            emit_event.command = run_status;
            emit_event.p1      = p1_q;
            emit_event.p2      = byte_data[6:0];
            if (VEL0_TO_NOTEOFF && run_status[7:4] == NOTE_ON && byte_data[6:0] == 7'd0) begin
               emit_event.command = {NOTE_OFF, run_status[3:0]};
               emit_event.p2      = 7'h40;
            end
         end
      end
   end

   midi_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .push       (emit),
      .push_event (emit_event),
      .pop        (midi_event_ack),
      .head       (head),
      .valid      (midi_event_valid),
      .level      (fifo_level),
      .overflow   (overflow)
   );

   assign midi_command     = head.command;
   assign midi_parameter_1 = head.p1;
   assign midi_parameter_2 = head.p2;

endmodule

`default_nettype wire

// File: tb/tb_midi_framer.sv
// ============================================================================
// tb_midi_framer : scoreboard bench for midi_framer (converting and raw variants)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_midi_framer;

   localparam int DEPTH = 4;

   typedef logic [7:0] bytes_t[$];

   logic       clk        = 1'b0;
   logic       resetn     = 1'b1;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data  = 8'h00;
   logic       ack        = 1'b0;

   logic       valid_c, valid_r;
   logic [7:0] cmd_c, cmd_r;
   logic [6:0] pa_c, pb_c, pa_r, pb_r;
   logic       ovf_c, ovf_r;
   logic [2:0] lvl_c, lvl_r;

   always #31 clk = ~clk;

   midi_framer #(.FIFO_DEPTH(DEPTH), .VEL0_TO_NOTEOFF(1'b1)) dut (
      .clk(clk), .resetn(resetn), .byte_valid(byte_valid), .byte_data(byte_data),
      .midi_event_valid(valid_c), .midi_command(cmd_c), .midi_parameter_1(pa_c),
      .midi_parameter_2(pb_c), .midi_event_ack(ack), .overflow(ovf_c), .fifo_level(lvl_c));

   midi_framer #(.FIFO_DEPTH(DEPTH), .VEL0_TO_NOTEOFF(1'b0)) dut_raw (
      .clk(clk), .resetn(resetn), .byte_valid(byte_valid), .byte_data(byte_data),
      .midi_event_valid(valid_r), .midi_command(cmd_r), .midi_parameter_1(pa_r),
      .midi_parameter_2(pb_r), .midi_event_ack(ack), .overflow(ovf_r), .fifo_level(lvl_r));

   // Scoreboard queues and the expected FIFO state as it stands before the next edge.
   logic [21:0] q_conv[$];
   logic [21:0] q_raw[$];
   int          snap_level = 0;
   bit          snap_ovf   = 1'b0;
   bit          exp_ovf    = 1'b0;
   int          tests      = 0;
   int          fails      = 0;

   // Reference parser: running status plus a list of collected data bytes.
   logic [7:0]  rs = 8'h00;
   logic [6:0]  coll[$];
   int          skip_left = 0;

   task automatic model_byte(input logic [7:0] b, output bit got, output logic [21:0] ev);
      int         need;
      logic [6:0] p2;
      got = 1'b0;
      ev  = '0;
      if (b >= 8'hF8) begin
      end else if (b >= 8'hF0) begin
         rs = 8'h00;
         coll.delete();
         case (b)
            8'hF0:        skip_left = -1;
            8'hF1, 8'hF3: skip_left = 1;
            8'hF2:        skip_left = 2;
            default:      skip_left = 0;
         endcase
      end else if (b >= 8'h80) begin
         rs = b;
         coll.delete();
         skip_left = 0;
      end else if (skip_left != 0) begin
         if (skip_left > 0) skip_left--;
      end else if (rs != 8'h00) begin
         coll.push_back(b[6:0]);
         need = (rs[7:4] == 4'hC || rs[7:4] == 4'hD) ? 1 : 2;
         if (coll.size() == need) begin
            p2 = 7'd0;
            if (need == 2) p2 = coll[1];
            got = 1'b1;
            ev  = {rs, coll[0], p2};
            coll.delete();
         end
      end
   endtask

   task automatic tick(input bit bv, input logic [7:0] b, input bit a);
      bit          got;
      logic [21:0] ev;
      logic [21:0] cv;
      int          lvl;
      @(posedge clk);
      #1;
      byte_valid = bv;
      byte_data  = b;
      ack        = a;
      lvl        = q_conv.size();
      snap_level = lvl;
      snap_ovf   = exp_ovf;
      if (bv) begin
         model_byte(b, got, ev);
         if (got) begin
            cv = ev;
            if (ev[21:18] == 4'h9 && ev[6:0] == 7'd0)
               cv = {4'h8, ev[17:14], ev[13:7], 7'h40};
            if (lvl < DEPTH || (a && lvl > 0)) begin
               q_conv.push_back(cv);
               q_raw.push_back(ev);
            end else begin
               exp_ovf = 1'b1;
            end
         end
      end
   endtask

   task automatic send_seq(input bytes_t s, input bit a);
      foreach (s[i]) tick(1'b1, s[i], a);
      tick(1'b0, 8'h00, a);
   endtask

   task automatic idle(input int n, input bit a);
      for (int i = 0; i < n; i++) tick(1'b0, 8'h00, a);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      resetn     = 1'b0;
      byte_valid = 1'b0;
      ack        = 1'b0;
      q_conv.delete();
      q_raw.delete();
      rs         = 8'h00;
      coll.delete();
      skip_left  = 0;
      exp_ovf    = 1'b0;
      snap_level = 0;
      snap_ovf   = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   function automatic logic [7:0] rand_byte();
      int r;
      r = $urandom_range(99);
      if (r < 50)      return 8'($urandom_range(127));
      else if (r < 74) return 8'($urandom_range(8'hEF, 8'h80));
      else if (r < 84) return 8'($urandom_range(8'hF7, 8'hF0));
      else             return 8'($urandom_range(8'hFF, 8'hF8));
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: compares DUT state to the scoreboard between clock edges.
   always @(negedge clk) begin
      if (!resetn) begin
         check("rst_valid",  {31'd0, valid_c | valid_r}, 32'd0);
         check("rst_level",  {26'd0, lvl_c, lvl_r}, 32'd0);
         check("rst_ovf",    {30'd0, ovf_c, ovf_r}, 32'd0);
         check("rst_event",  {10'd0, cmd_c, pa_c, pb_c}, 32'd0);
      end else begin
         check("level",      32'(lvl_c), 32'(snap_level));
         check("level_raw",  32'(lvl_r), 32'(snap_level));
         check("valid",      32'(valid_c), 32'(snap_level != 0));
         check("overflow",   32'(ovf_c), 32'(snap_ovf));
         check("overflow_raw", 32'(ovf_r), 32'(snap_ovf));
         if (valid_c && ack) begin
            if (q_conv.size() == 0) check("pop_empty", 32'd1, 32'd0);
            else check("event", 32'({cmd_c, pa_c, pb_c}), 32'(q_conv.pop_front()));
         end
         if (valid_r && ack) begin
            if (q_raw.size() == 0) check("pop_empty_raw", 32'd1, 32'd0);
            else check("event_raw", 32'({cmd_r, pa_r, pb_r}), 32'(q_raw.pop_front()));
         end
      end
   end

   initial begin
      bytes_t seq;
      #5 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      seq = {8'h90, 8'h3C, 8'h64};                        send_seq(seq, 1'b0); idle(2, 1'b0); idle(3, 1'b1);
      seq = {8'h90, 8'h3C, 8'h64, 8'h40, 8'h50};          send_seq(seq, 1'b0); idle(4, 1'b1);
      seq = {8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64};          send_seq(seq, 1'b0);
      seq = {8'hC2, 8'h05};                               send_seq(seq, 1'b0); idle(4, 1'b1);
      seq = {8'hF0, 8'h01, 8'h02, 8'h03, 8'hF7, 8'h3C, 8'h64}; send_seq(seq, 1'b0);
      seq = {8'hB0, 8'h01, 8'h7F};                        send_seq(seq, 1'b0); idle(3, 1'b1);
      seq = {8'h91, 8'h3C, 8'h00};                        send_seq(seq, 1'b0); idle(3, 1'b1);
      seq = {8'hF2, 8'h10, 8'h20, 8'h30, 8'hF1, 8'h40, 8'h50}; send_seq(seq, 1'b0); idle(2, 1'b1);

      seq = {8'h90, 8'h3C, 8'h64, 8'h3D, 8'h64, 8'h3E, 8'h64,
             8'h3F, 8'h64, 8'h40, 8'h64, 8'h41, 8'h64};
      send_seq(seq, 1'b0);
      idle(2, 1'b0);
      idle(4, 1'b1);
      idle(2, 1'b0);

      seq = {8'h90, 8'h3C};                               send_seq(seq, 1'b0);
      pulse_reset();
      seq = {8'h64};                                      send_seq(seq, 1'b0); idle(2, 1'b1);

      for (int phase = 0; phase < 4; phase++) begin
         for (int i = 0; i < 2000; i++)
            tick($urandom_range(99) < 60, rand_byte(),
                 $urandom_range(99) < ((phase % 2 == 0) ? 70 : 15));
         if (phase == 1) pulse_reset();
      end
      idle(8, 1'b1);
      idle(2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
